// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory fields, pipeline control, and the registered D-stage payload.
interface fetch_if;
  logic [31:0] F_valP;
  logic [5:0]  f_op;
  logic [5:0]  f_func;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [31:0] f_valC;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic        d_jump;
  logic [31:0] d_jtarget;
  logic        e_redirect;
  logic [31:0] e_target;
  logic [5:0]  D_op;
  logic [5:0]  D_func;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [4:0]  D_rd;
  logic [31:0] D_valC;
  logic [31:0] D_pcp4;
  logic        D_valid;
  logic [31:0] fetch_count;

  // Control and memory side.
  modport master (
    output f_op, f_func, f_rs, f_rt, f_rd, f_valC,
    output F_stall, D_stall, D_bubble, d_jump, d_jtarget, e_redirect, e_target,
    input  F_valP, D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_pcp4, D_valid, fetch_count
  );

  // Fetch stage itself.
  modport slave (
    input  f_op, f_func, f_rs, f_rt, f_rd, f_valC,
    input  F_stall, D_stall, D_bubble, d_jump, d_jtarget, e_redirect, e_target,
    output F_valP, D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_pcp4, D_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch PC register and F->D pipeline register with redirect/jump squash and an accepted-instruction count.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.slave   bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned REGW = 5;

  logic [XLEN-1:0] pc_q,    pc_d;
  logic [OPW-1:0]  op_q,    op_d;
  logic [OPW-1:0]  func_q,  func_d;
  logic [REGW-1:0] rs_q,    rs_d;
  logic [REGW-1:0] rt_q,    rt_d;
  logic [REGW-1:0] rd_q,    rd_d;
  logic [XLEN-1:0] valc_q,  valc_d;
  logic [XLEN-1:0] pcp4_q,  pcp4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] cnt_q,   cnt_d;

  logic            jump_ok;
  logic [XLEN-1:0] pc_plus4;
  logic            unused_tgt_bits;

  // Low target bits are discarded; instructions are word aligned.
  assign unused_tgt_bits = ^{bus.e_target[1:0], bus.d_jtarget[1:0]};

  // A jump only counts when it comes from a live, advancing decode slot.
  assign jump_ok  = bus.d_jump & valid_q & ~bus.D_stall;
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next PC.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.e_redirect) begin
      pc_d = {bus.e_target[XLEN-1:2], 2'b00};
    end else if (bus.F_stall) begin
      pc_d = pc_q;
    end else if (jump_ok) begin
      pc_d = {bus.d_jtarget[XLEN-1:2], 2'b00};
    end
  end

  // Next D register: squash, hold, or load.
  always_comb begin
    op_d    = op_q;
    func_d  = func_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    valc_d  = valc_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.e_redirect || bus.D_bubble || (!bus.D_stall && jump_ok)) begin
      op_d    = '0;
      func_d  = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      valc_d  = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
    end else if (!bus.D_stall) begin
      op_d    = bus.f_op;
      func_d  = bus.f_func;
      rs_d    = bus.f_rs;
      rt_d    = bus.f_rt;
      rd_d    = bus.f_rd;
      valc_d  = bus.f_valC;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      op_q    <= '0;
      func_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valc_q  <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      op_q    <= op_d;
      func_q  <= func_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valc_q  <= valc_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.F_valP      = pc_q;
  assign bus.D_op        = op_q;
  assign bus.D_func      = func_q;
  assign bus.D_rs        = rs_q;
  assign bus.D_rt        = rt_q;
  assign bus.D_rd        = rd_q;
  assign bus.D_valC      = valc_q;
  assign bus.D_pcp4      = pcp4_q;
  assign bus.D_valid     = valid_q;
  assign bus.fetch_count = cnt_q;

endmodule
